// File: rtl/bcd_to_decimal_dec.sv
// Streaming BCD digit to one-hot decimal decoder behind a 2-entry registered skid buffer.
// Codes 10-15 are forwarded as error entries and counted in a saturating status counter.
module bcd_to_decimal_dec #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           bcd_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [9:0]           dec_out,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  typedef struct packed {
    logic       err;
    logic [9:0] dec;
  } entry_t;

  entry_t                 new_entry;
  entry_t                 head_q, head_d;
  entry_t                 tail_q, tail_d;
  logic [1:0]             occ_q, occ_d;
  logic                   rdy_q;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   accept;
  logic                   pop;

  always_comb begin
    new_entry = '0;
    if (bcd_in <= 4'd9) begin
      new_entry.dec = 10'b1 << bcd_in;
    end else begin
      new_entry.err = 1'b1;
    end
  end

  assign accept = in_valid && rdy_q;
  assign pop    = (occ_q != 2'd0) && out_ready;

  // Head always holds the oldest entry; vacated slots are zeroed so an empty
  // buffer presents all-zero outputs without extra gating.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({accept, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = new_entry;
        end else begin
          tail_d = new_entry;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        tail_d = '0;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = new_entry;
        end else begin
          head_d = tail_q;
          tail_d = new_entry;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = '0;
    end else if (accept && new_entry.err && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // in_ready is registered from next occupancy so it never follows out_ready
  // combinationally, and stays low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      rdy_q  <= (occ_d < 2'd2);
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (occ_q != 2'd0);
  assign dec_out   = head_q.dec;
  assign out_err   = head_q.err;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_bcd_to_decimal_dec.sv
// Randomised and directed bench for bcd_to_decimal_dec against a queue-based reference model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_bcd_to_decimal_dec;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] dec_out;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_count;
  logic       clr_err;

  logic       in_ready2;
  logic [9:0] dec_out2;
  logic       out_err2;
  logic       out_valid2;
  logic [1:0] err_count2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [10:0] q[$];
  bit          m_rdy;
  int          cnt8;
  int          cnt2;

  bcd_to_decimal_dec #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec_out   (dec_out),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count),
    .clr_err   (clr_err)
  );

  bcd_to_decimal_dec #(.ERR_CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .dec_out   (dec_out2),
    .out_err   (out_err2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .err_count (err_count2),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ref_decode(input logic [3:0] b);
    logic [9:0] d;
    d = '0;
    if (b < 4'd10) begin
      d[b] = 1'b1;
      return {1'b0, d};
    end
    return {1'b1, 10'd0};
  endfunction

  function automatic logic [9:0] m_dec();
    if (q.size() == 0) return 10'd0;
    return q[0][9:0];
  endfunction

  function automatic logic m_err();
    if (q.size() == 0) return 1'b0;
    return q[0][10];
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0;
    cnt8  = 0;
    cnt2  = 0;
  endtask

  // Drives one clock cycle of stimulus and advances the model across the edge.
  task automatic cycle(input logic iv, input logic [3:0] b, input logic ordy, input logic clr);
    bit          acc;
    bit          pop;
    logic [10:0] gone;
    in_valid  = iv;
    bcd_in    = b;
    out_ready = ordy;
    clr_err   = clr;
    acc = iv && m_rdy;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pop) gone = q.pop_front();
      if (acc) q.push_back(ref_decode(b));
      if (clr) begin
        cnt8 = 0;
        cnt2 = 0;
      end else if (acc && b > 4'd9) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      m_rdy = (q.size() < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || dec_out !== 10'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b dec=%b err=%b required 0/0/0", out_valid, dec_out,
               out_err);
    end
    checks++;
    if (in_ready !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_ready_cnt: in_ready=%b err_count=%0d required 0/0", in_ready, err_count);
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_before_edge: in_ready=%b required 0", in_ready);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_after_edge: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'(k), 1'b1, 1'b0);
      checks++;
      if (dec_out !== (10'd1 << k) || out_err !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_digit%0d: dec=%b err=%b valid=%b required %b/0/1", k, dec_out, out_err,
                 out_valid, 10'd1 << k);
      end
    end
    checks++;
    if (err_count !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL seq_status: err_count=%0d in_ready=%b required 0/1", err_count, in_ready);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || dec_out !== 10'd0) begin
      failures++;
      $display("FAIL seq_drain: valid=%b dec=%b required 0/0", out_valid, dec_out);
    end
  endtask

  task automatic test_stall();
    int base;
    base = cnt8;
    cycle(1'b1, 4'd3, 1'b0, 1'b0);
    cycle(1'b1, 4'd7, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || dec_out !== 10'b0000001000) begin
      failures++;
      $display("FAIL stall_full: in_ready=%b dec=%b required 0/0000001000", in_ready, dec_out);
    end
    cycle(1'b1, 4'd12, 1'b0, 1'b0);
    checks++;
    if (dec_out !== 10'b0000001000 || out_err !== 1'b0 || err_count !== 8'(base)) begin
      failures++;
      $display("FAIL stall_hold: dec=%b err=%b cnt=%0d required 0000001000/0/%0d", dec_out,
               out_err, err_count, base);
    end
    cycle(1'b1, 4'd12, 1'b1, 1'b0);
    checks++;
    if (dec_out !== 10'b0010000000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_pop1: dec=%b in_ready=%b required 0010000000/1", dec_out, in_ready);
    end
    cycle(1'b1, 4'd12, 1'b1, 1'b0);
    checks++;
    if (dec_out !== 10'd0 || out_err !== 1'b1 || out_valid !== 1'b1 ||
        err_count !== 8'(base + 1)) begin
      failures++;
      $display("FAIL stall_invalid: dec=%b err=%b valid=%b cnt=%0d required 0/1/1/%0d", dec_out,
               out_err, out_valid, err_count, base + 1);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 4'd2, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    checks++;
    if (dec_out !== 10'b0000100000 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_occ1: dec=%b valid=%b in_ready=%b required 0000100000/1/1", dec_out,
               out_valid, in_ready);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_drain: valid=%b required 0 (occupancy should have stayed 1)",
               out_valid);
    end
  endtask

  task automatic test_err_sat();
    int exp2[5] = '{1, 2, 3, 3, 3};
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'd15, 1'b1, 1'b0);
      checks++;
      if (err_count2 !== 2'(exp2[i]) || err_count !== 8'(i + 1) || out_err !== 1'b1) begin
        failures++;
        $display("FAIL sat_w2_step%0d: cnt2=%0d cnt8=%0d err=%b required %0d/%0d/1", i,
                 err_count2, err_count, out_err, exp2[i], i + 1);
      end
    end
    cycle(1'b1, 4'd14, 1'b1, 1'b1);
    checks++;
    if (err_count2 !== 2'd0 || err_count !== 8'd0 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL clr_priority: cnt2=%0d cnt8=%0d err=%b required 0/0/1", err_count2,
               err_count, out_err);
    end
    for (int i = 0; i < 260; i++) cycle(1'b1, 4'(10 + (i % 6)), 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd255 || err_count2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_w8: cnt8=%0d cnt2=%0d required 255/3", err_count, err_count2);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 4'd4, 1'b0, 1'b0);
    cycle(1'b1, 4'd9, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dec_out !== 10'b0000010000 || err_count === 8'd0) begin
      failures++;
      $display("FAIL arst_prefill: valid=%b dec=%b cnt=%0d required 1/0000010000/nonzero",
               out_valid, dec_out, err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dec_out !== 10'd0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: valid=%b dec=%b cnt=%0d rdy=%b required 0/0/0/0", out_valid,
               dec_out, err_count, in_ready);
    end
    model_reset();
    #1 rst_n = 1'b1;
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    checks++;
    if (dec_out !== 10'b0000000010 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_push1: dec=%b valid=%b required 0000000010/1", dec_out, out_valid);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      checks++;
      if (out_valid !== (q.size() > 0) || dec_out !== m_dec() || out_err !== m_err() ||
          in_ready !== m_rdy || err_count !== 8'(cnt8) || err_count2 !== 2'(cnt2)) begin
        failures++;
        $display("FAIL random_cycle%0d: valid=%b dec=%b err=%b rdy=%b cnt=%0d cnt2=%0d required %b/%b/%b/%b/%0d/%0d",
                 i, out_valid, dec_out, out_err, in_ready, err_count, err_count2,
                 q.size() > 0, m_dec(), m_err(), m_rdy, cnt8, cnt2);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bcd_in    = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    model_reset();
    test_reset();
    test_sequence();
    test_stall();
    test_simultaneous();
    test_err_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_decimal_dec.md
Name: bcd_to_decimal_dec

Overview:
Streaming BCD-to-decimal decoder, the inverse of the team's one-hot decimal-to-BCD encoder. Accepts one 4-bit BCD digit per valid/ready handshake. Emits the 10-bit one-hot decimal line vector through a 2-entry registered skid buffer. Flags non-BCD codes (10-15) and keeps a saturating error count for status readback.

Parameters:
ERR_CNT_W, 8, width of saturating invalid-code counter (legal 1..16)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4  BCD digit, valid only with in_valid
in_valid  input  1  upstream offers bcd_in
in_ready  output  1  block can accept a digit this cycle
dec_out  output  10  one-hot decimal of head entry; bit n set for digit n
out_err  output  1  head entry came from an invalid code (10-15)
out_valid  output  1  head entry present
out_ready  input  1  downstream accepts head entry this cycle
err_count  output  ERR_CNT_W  number of invalid codes accepted, saturating
clr_err  input  1  synchronous clear of err_count

Behaviour:
- Reset: the only reset is asynchronous active-low rst_n. It clears both buffer entries, occupancy=0, out_valid=0, dec_out=0, out_err=0, err_count=0. in_ready=0 while rst_n low; in_ready=1 from the first edge after release.
- Accept: a digit is accepted on an edge where in_valid && in_ready. Present: the head entry is consumed on an edge where out_valid && out_ready.
- Decode (combinational, applied on accept):
  - code k in 0..9 -> entry {dec = 1<<k, err = 0}
  - codes 10..15 -> entry {dec = 10'b0, err = 1}
  - Invalid entries are forwarded in order, never dropped.
- Buffer: 2-entry FIFO; occupancy 0/1/2.
  - in_ready = (occupancy < 2), registered or derived from occupancy only; it must not depend combinationally on out_ready.
  - out_valid = (occupancy > 0).
- Latency: accept at edge N into an empty buffer -> out_valid=1 and dec_out valid after edge N (visible in cycle N+1). Throughput is 1 digit/cycle when out_ready is held high.
- Ordering: strict FIFO; dec_out/out_err always reflect the oldest unconsumed entry.
- Stability: while out_valid && !out_ready, dec_out and out_err hold constant.
- Empty: dec_out=0, out_err=0, out_valid=0.
- Simultaneous accept and present:
  - occupancy 1 -> stays 1; the new entry becomes head after the edge.
  - occupancy 2 -> no accept possible (in_ready=0); occupancy becomes 1 and in_ready rises next cycle.
- Full: occupancy 2 with out_ready low -> in_ready=0 and in_valid is ignored; bcd_in must not be sampled.
- err_count:
  - +1 on each accept of an invalid code.
  - Saturates at all-ones with no wrap.
  - clr_err has priority: if clr_err is high, next value is 0 even if an invalid accept happens the same edge.
- Reset mid-operation: rst_n low at any time immediately flushes buffered entries and the counter. No partial output is produced after release.

Test Plan:
- Reset, then push 0..9 back-to-back with out_ready=1 -> dec_out = 10'b0000000001, 0000000010, ... 1000000000 on consecutive cycles, each one cycle after its accept; out_err=0; err_count=0.
- Push 3, 7, 12 with out_ready=0 -> in_ready drops after the 2nd accept, so 12 is stalled and dec_out holds 10'b0000001000. Raise out_ready -> outputs 0000001000, then 0010000000, then 12 is accepted and emitted as dec_out=0 with out_err=1; err_count=1.
- Occupancy 1, in_valid and out_ready high same edge with digit 5 -> occupancy stays 1 and next dec_out=10'b0000100000.
- ERR_CNT_W=2: push 15 five times -> err_count goes 1,2,3,3,3. Assert clr_err on the same edge as a 6th invalid accept -> err_count=0.
- Fill buffer with 4, 9, then pulse rst_n low between edges -> out_valid, dec_out and err_count go to 0 immediately, without waiting for a clock edge; after release in_ready=1 and the next push of 1 yields dec_out=10'b0000000010.
